// File: rtl/traffic_sensor_model.sv
// Closed-loop road model for the traffic-light controller: per-road car queues, TA/TB sensors, light safety monitor.
// Optional build macro TRAFFIC_SENSOR_YELLOW_GO_EN lets cars keep departing on YELLOW.
module traffic_sensor_model #(
   parameter int QW            = 4,
   parameter int DEPART_CYCLES = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          arrive_a,
   input  logic          arrive_b,
   input  logic [1:0]    LA,
   input  logic [1:0]    LB,
   output logic          TA,
   output logic          TB,
   output logic [QW-1:0] count_a,
   output logic [QW-1:0] count_b,
   output logic          ovf_a,
   output logic          ovf_b,
   output logic          light_err
);

   typedef enum logic [1:0] {
      LIGHT_GREEN  = 2'b00,
      LIGHT_YELLOW = 2'b01,
      LIGHT_RED    = 2'b10,
      LIGHT_BAD    = 2'b11
   } light_e;

   typedef struct packed {
      logic [QW-1:0] count;
      logic [3:0]    dep;
      logic          ovf;
   } road_t;

   localparam logic [QW-1:0] CNT_MAX  = {QW{1'b1}};
   localparam logic [3:0]    DEP_LAST = 4'(DEPART_CYCLES - 1);

   road_t road_a_q, road_a_d;
   road_t road_b_q, road_b_d;
   logic  ta_q, ta_d;
   logic  tb_q, tb_d;
   logic  light_err_q, light_err_d;
   logic  go_a, go_b;

   function automatic logic is_go(input logic [1:0] light);
`ifdef TRAFFIC_SENSOR_YELLOW_GO_EN
      return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
`else
      return (light == LIGHT_GREEN);
`endif
   endfunction

   // The departure timer only runs while the light is go and cars are waiting;
   // any break in either condition discards partial credit.
   function automatic road_t road_next(input road_t cur, input logic go, input logic arrive);
      road_t nxt;
      logic  depart;
      nxt    = cur;
      nxt.dep = '0;
      depart = 1'b0;
      if (go && (cur.count != '0)) begin
         if (cur.dep == DEP_LAST) depart = 1'b1;
         else                     nxt.dep = cur.dep + 4'd1;
      end
      if (arrive && !depart) begin
         if (cur.count == CNT_MAX) nxt.ovf   = 1'b1;
         else                      nxt.count = cur.count + QW'(1);
      end else if (depart && !arrive) begin
         nxt.count = cur.count - QW'(1);
      end
      return nxt;
   endfunction

   always_comb begin
      go_a     = is_go(LA);
      go_b     = is_go(LB);
      road_a_d = road_next(road_a_q, go_a, arrive_a);
      road_b_d = road_next(road_b_q, go_b, arrive_b);
      ta_d     = (road_a_d.count != '0);
      tb_d     = (road_b_d.count != '0);
      light_err_d = light_err_q
                  || (LA == LIGHT_BAD) || (LB == LIGHT_BAD)
                  || ((LA != LIGHT_RED) && (LB != LIGHT_RED));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         road_a_q    <= '0;
         road_b_q    <= '0;
         ta_q        <= 1'b0;
         tb_q        <= 1'b0;
         light_err_q <= 1'b0;
      end else begin
         road_a_q    <= road_a_d;
         road_b_q    <= road_b_d;
         ta_q        <= ta_d;
         tb_q        <= tb_d;
         light_err_q <= light_err_d;
      end
   end

   assign TA        = ta_q;
   assign TB        = tb_q;
   assign count_a   = road_a_q.count;
   assign count_b   = road_b_q.count;
   assign ovf_a     = road_a_q.ovf;
   assign ovf_b     = road_b_q.ovf;
   assign light_err = light_err_q;

endmodule

// File: tb/tb_traffic_sensor_model.sv
// Directed-vector bench for traffic_sensor_model (QW=4, DEPART_CYCLES=3); honours TRAFFIC_SENSOR_YELLOW_GO_EN.
module tb_traffic_sensor_model;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;
   localparam logic [1:0] BAD    = 2'b11;

`ifdef TRAFFIC_SENSOR_YELLOW_GO_EN
   localparam bit YELLOW_GO = 1'b1;
`else
   localparam bit YELLOW_GO = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       arrive_a;
   logic       arrive_b;
   logic [1:0] LA;
   logic [1:0] LB;
   logic       TA;
   logic       TB;
   logic [3:0] count_a;
   logic [3:0] count_b;
   logic       ovf_a;
   logic       ovf_b;
   logic       light_err;

   int checks = 0;
   int errors = 0;

   traffic_sensor_model #(.QW(4), .DEPART_CYCLES(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .arrive_a  (arrive_a),
      .arrive_b  (arrive_b),
      .LA        (LA),
      .LB        (LB),
      .TA        (TA),
      .TB        (TB),
      .count_a   (count_a),
      .count_b   (count_b),
      .ovf_a     (ovf_a),
      .ovf_b     (ovf_b),
      .light_err (light_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      arrive_a = 1'b0;
      arrive_b = 1'b0;
      LA       = RED;
      LB       = RED;
      reset    = 1'b1;
      tick(1);
      reset    = 1'b0;
   endtask

   task automatic fill_a(input int n);
      arrive_a = 1'b1;
      tick(n);
      arrive_a = 1'b0;
   endtask

   task automatic test_reset();
      arrive_a = 1'b0;
      arrive_b = 1'b0;
      LA       = RED;
      LB       = RED;
      reset    = 1'b1;
      #2;
      checks++;
      if ({TA, TB, count_a, count_b, ovf_a, ovf_b, light_err} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs got TA=%b TB=%b ca=%0d cb=%0d oa=%b ob=%b err=%b want all 0",
                  TA, TB, count_a, count_b, ovf_a, ovf_b, light_err);
      end
      tick(1);
      reset = 1'b0;
   endtask

   task automatic test_fill();
      apply_reset();
      arrive_a = 1'b1;
      tick(1);
      checks++;
      if (count_a !== 4'd1 || TA !== 1'b1) begin
         errors++;
         $display("FAIL fill_first got count_a=%0d TA=%b want 1 1", count_a, TA);
      end
      tick(2);
      arrive_a = 1'b0;
      checks++;
      if (count_a !== 4'd3 || TA !== 1'b1 || TB !== 1'b0) begin
         errors++;
         $display("FAIL fill_three got count_a=%0d TA=%b TB=%b want 3 1 0", count_a, TA, TB);
      end
   endtask

   task automatic test_drain();
      apply_reset();
      fill_a(2);
      LA = GREEN;
      tick(2);
      checks++;
      if (count_a !== 4'd2) begin
         errors++;
         $display("FAIL drain_edge2 got count_a=%0d want 2", count_a);
      end
      tick(1);
      checks++;
      if (count_a !== 4'd1) begin
         errors++;
         $display("FAIL drain_edge3 got count_a=%0d want 1", count_a);
      end
      tick(3);
      checks++;
      if (count_a !== 4'd0 || TA !== 1'b0) begin
         errors++;
         $display("FAIL drain_edge6 got count_a=%0d TA=%b want 0 0", count_a, TA);
      end
      // Idle while green, then one arrival: its departure needs a full fresh timer.
      tick(1);
      fill_a(1);
      tick(2);
      checks++;
      if (count_a !== 4'd1) begin
         errors++;
         $display("FAIL drain_timer_idle got count_a=%0d want 1", count_a);
      end
      tick(1);
      checks++;
      if (count_a !== 4'd0 || TA !== 1'b0) begin
         errors++;
         $display("FAIL drain_refill_depart got count_a=%0d TA=%b want 0 0", count_a, TA);
      end
      LA = RED;
   endtask

   task automatic test_simultaneous();
      apply_reset();
      fill_a(2);
      LA = GREEN;
      tick(2);
      arrive_a = 1'b1;
      tick(1);
      arrive_a = 1'b0;
      checks++;
      if (count_a !== 4'd2 || TA !== 1'b1) begin
         errors++;
         $display("FAIL simul_arrive_depart got count_a=%0d TA=%b want 2 1", count_a, TA);
      end
      tick(3);
      checks++;
      if (count_a !== 4'd1) begin
         errors++;
         $display("FAIL simul_next_depart got count_a=%0d want 1", count_a);
      end
      LA = RED;
   endtask

   task automatic test_full();
      apply_reset();
      arrive_b = 1'b1;
      tick(15);
      checks++;
      if (count_b !== 4'd15 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL full_15 got count_b=%0d ovf_b=%b want 15 0", count_b, ovf_b);
      end
      tick(1);
      arrive_b = 1'b0;
      checks++;
      if (count_b !== 4'd15 || ovf_b !== 1'b1 || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL full_16 got count_b=%0d ovf_b=%b ovf_a=%b want 15 1 0", count_b, ovf_b, ovf_a);
      end
      LB = GREEN;
      tick(45);
      checks++;
      if (count_b !== 4'd0 || TB !== 1'b0 || ovf_b !== 1'b1 || light_err !== 1'b0) begin
         errors++;
         $display("FAIL full_drain got count_b=%0d TB=%b ovf_b=%b err=%b want 0 0 1 0",
                  count_b, TB, ovf_b, light_err);
      end
      LB = RED;
   endtask

   task automatic test_safety();
      apply_reset();
      LA = YELLOW;
      LB = RED;
      tick(2);
      checks++;
      if (light_err !== 1'b0) begin
         errors++;
         $display("FAIL safety_yellow_red_legal got light_err=%b want 0", light_err);
      end
      LA = GREEN;
      LB = YELLOW;
      tick(1);
      LA = RED;
      LB = RED;
      checks++;
      if (light_err !== 1'b1) begin
         errors++;
         $display("FAIL safety_conflict got light_err=%b want 1", light_err);
      end
      tick(3);
      checks++;
      if (light_err !== 1'b1) begin
         errors++;
         $display("FAIL safety_sticky got light_err=%b want 1", light_err);
      end
      apply_reset();
      LA = BAD;
      checks++;
      if (light_err !== 1'b0) begin
         errors++;
         $display("FAIL safety_before_edge got light_err=%b want 0", light_err);
      end
      tick(1);
      LA = RED;
      checks++;
      if (light_err !== 1'b1) begin
         errors++;
         $display("FAIL safety_illegal_code got light_err=%b want 1", light_err);
      end
   endtask

   task automatic test_yellow();
      logic [3:0] exp_cnt;
      apply_reset();
      fill_a(1);
      LA = GREEN;
      tick(2);
      LA = YELLOW;
      tick(2);
      exp_cnt = YELLOW_GO ? 4'd0 : 4'd1;
      checks++;
      if (count_a !== exp_cnt) begin
         errors++;
         $display("FAIL yellow_departure got count_a=%0d want %0d", count_a, exp_cnt);
      end
      // Back to green: without yellow-go the earlier green credit is gone.
      LA = GREEN;
      tick(2);
      checks++;
      if (count_a !== exp_cnt) begin
         errors++;
         $display("FAIL yellow_no_credit got count_a=%0d want %0d", count_a, exp_cnt);
      end
      tick(1);
      checks++;
      if (count_a !== 4'd0) begin
         errors++;
         $display("FAIL yellow_regreen_depart got count_a=%0d want 0", count_a);
      end
      LA = RED;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      arrive_b = 1'b1;
      fill_a(2);
      arrive_b = 1'b0;
      LA = GREEN;
      LB = GREEN;
      tick(2);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({TA, TB, count_a, count_b, ovf_a, ovf_b, light_err} !== 13'd0) begin
         errors++;
         $display("FAIL reset_mid got TA=%b TB=%b ca=%0d cb=%0d oa=%b ob=%b err=%b want all 0",
                  TA, TB, count_a, count_b, ovf_a, ovf_b, light_err);
      end
      LB = RED;
      tick(1);
      reset = 1'b0;
      fill_a(1);
      tick(2);
      checks++;
      if (count_a !== 4'd1) begin
         errors++;
         $display("FAIL reset_mid_no_pending got count_a=%0d want 1", count_a);
      end
      tick(1);
      checks++;
      if (count_a !== 4'd0 || light_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fresh_depart got count_a=%0d err=%b want 0 0", count_a, light_err);
      end
      LA = RED;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_full();
      test_safety();
      test_yellow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
